// File: rtl/bus_arbiter.sv
// Two-master arbiter serialising accesses onto the shared register bus.
// Define BUS_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise master 0 wins.
module bus_arbiter #(
    parameter int address_width = 15,
    parameter int data_width    = 16,
    parameter int ReadLatency   = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     m0_req_i,
    input  logic [address_width-1:0] m0_address_i,
    input  logic [data_width-1:0]    m0_data_i,
    input  logic                     m0_rd_wr_i,
    output logic                     m0_ack_o,
    output logic [data_width-1:0]    m0_data_o,
    input  logic                     m1_req_i,
    input  logic [address_width-1:0] m1_address_i,
    input  logic [data_width-1:0]    m1_data_i,
    input  logic                     m1_rd_wr_i,
    output logic                     m1_ack_o,
    output logic [data_width-1:0]    m1_data_o,
    output logic [address_width-1:0] bus_address_o,
    output logic [data_width-1:0]    bus_data_o,
    output logic                     bus_rd_wr_o,
    input  logic [data_width-1:0]    bus_data_i,
    output logic                     busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        WAIT,
        ACK
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [2:0] cnt_q;
    logic       grant_q;
    logic       dir_q;
    logic       win;
    logic       any_req;

    assign any_req = m0_req_i | m1_req_i;

`ifdef BUS_ARB_ROUND_ROBIN_EN
    logic last_q;

    always_comb begin
        win = m1_req_i;
        if (m0_req_i && m1_req_i) begin
            win = ~last_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_q <= 1'b1;
        end else if (state_q == IDLE && any_req) begin
            last_q <= win;
        end
    end
`else
    always_comb begin
        win = m1_req_i & ~m0_req_i;
    end
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (any_req) state_d = XFER;
            XFER: state_d = (ReadLatency > 1) ? WAIT : ACK;
            WAIT: if (cnt_q <= 3'd1) state_d = ACK;
            ACK:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            cnt_q         <= 3'd0;
            grant_q       <= 1'b0;
            dir_q         <= 1'b0;
            bus_address_o <= '0;
            bus_data_o    <= '0;
            m0_data_o     <= '0;
            m1_data_o     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && any_req) begin
                grant_q       <= win;
                bus_address_o <= win ? m1_address_i : m0_address_i;
                bus_data_o    <= win ? m1_data_i : m0_data_i;
                dir_q         <= win ? m1_rd_wr_i : m0_rd_wr_i;
            end
            if (state_q == XFER) begin
                cnt_q <= 3'(ReadLatency - 1);
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q - 3'd1;
            end
            // Read data is captured on the edge that enters ACK
            if (state_d == ACK && !dir_q) begin
                if (grant_q) begin
                    m1_data_o <= bus_data_i;
                end else begin
                    m0_data_o <= bus_data_i;
                end
            end
        end
    end

    assign bus_rd_wr_o = (state_q == XFER) && dir_q && !reset_i;
    assign m0_ack_o    = (state_q == ACK) && !grant_q && !reset_i;
    assign m1_ack_o    = (state_q == ACK) && grant_q && !reset_i;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (ReadLatency 2 and 1).
module tb_bus_arbiter;

    logic        clk;
    logic        reset_i;
    logic        m0_req, m0_rd_wr, m1_req, m1_rd_wr;
    logic [14:0] m0_address, m1_address;
    logic [15:0] m0_data, m1_data, bus_data_i;

    logic        m0_ack_o, m1_ack_o, bus_rd_wr_o, busy_o;
    logic [15:0] m0_data_o, m1_data_o, bus_data_o;
    logic [14:0] bus_address_o;

    logic        o1_m0_ack, o1_m1_ack, o1_rd_wr, o1_busy;
    logic [15:0] o1_m0_data, o1_m1_data, o1_bus_data;
    logic [14:0] o1_bus_address;

    int n_checks = 0;
    int n_fail = 0;

    bus_arbiter #(.address_width(15), .data_width(16), .ReadLatency(2)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .m0_req_i(m0_req), .m0_address_i(m0_address), .m0_data_i(m0_data),
        .m0_rd_wr_i(m0_rd_wr), .m0_ack_o(m0_ack_o), .m0_data_o(m0_data_o),
        .m1_req_i(m1_req), .m1_address_i(m1_address), .m1_data_i(m1_data),
        .m1_rd_wr_i(m1_rd_wr), .m1_ack_o(m1_ack_o), .m1_data_o(m1_data_o),
        .bus_address_o(bus_address_o), .bus_data_o(bus_data_o),
        .bus_rd_wr_o(bus_rd_wr_o), .bus_data_i(bus_data_i), .busy_o(busy_o)
    );

    bus_arbiter #(.address_width(15), .data_width(16), .ReadLatency(1)) dut1 (
        .clk_i(clk), .reset_i(reset_i),
        .m0_req_i(m0_req), .m0_address_i(m0_address), .m0_data_i(m0_data),
        .m0_rd_wr_i(m0_rd_wr), .m0_ack_o(o1_m0_ack), .m0_data_o(o1_m0_data),
        .m1_req_i(m1_req), .m1_address_i(m1_address), .m1_data_i(m1_data),
        .m1_rd_wr_i(m1_rd_wr), .m1_ack_o(o1_m1_ack), .m1_data_o(o1_m1_data),
        .bus_address_o(o1_bus_address), .bus_data_o(o1_bus_data),
        .bus_rd_wr_o(o1_rd_wr), .bus_data_i(bus_data_i), .busy_o(o1_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        m;
        logic        rw;
        logic [14:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        logic [15:0] exp0;
        logic [15:0] exp1;
    } vec_t;

    vec_t vecs[6];
    vec_t after_rst;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_reqs;
        m0_req = 1'b0;
        m1_req = 1'b0;
    endtask

    task automatic do_reset;
        reset_i = 1'b1;
        clear_reqs();
        tick();
        reset_i = 1'b0;
        tick();
    endtask

    task automatic run_vec(input vec_t v);
        if (v.m) begin
            m1_req = 1'b1; m1_address = v.addr; m1_data = v.wdata; m1_rd_wr = v.rw;
        end else begin
            m0_req = 1'b1; m0_address = v.addr; m0_data = v.wdata; m0_rd_wr = v.rw;
        end
        bus_data_i = v.rdata;
        tick();
        chk("xfer_addr", 32'(bus_address_o), 32'(v.addr));
        chk("xfer_strobe", 32'(bus_rd_wr_o), 32'(v.rw));
        if (v.rw) chk("xfer_wdata", 32'(bus_data_o), 32'(v.wdata));
        chk("xfer_busy", 32'(busy_o), 32'd1);
        tick();
        chk("wait_strobe", 32'(bus_rd_wr_o), 32'd0);
        chk("wait_ack", 32'({m1_ack_o, m0_ack_o}), 32'd0);
        tick();
        chk("ack", 32'({m1_ack_o, m0_ack_o}), v.m ? 32'd2 : 32'd1);
        chk("ack_strobe", 32'(bus_rd_wr_o), 32'd0);
        chk("m0_data", 32'(m0_data_o), 32'(v.exp0));
        chk("m1_data", 32'(m1_data_o), 32'(v.exp1));
        clear_reqs();
        tick();
        chk("idle_busy", 32'(busy_o), 32'd0);
        chk("idle_ack", 32'({m1_ack_o, m0_ack_o}), 32'd0);
        chk("idle_hold_addr", 32'(bus_address_o), 32'(v.addr));
    endtask

    initial begin
        logic rr;
        logic w;
`ifdef BUS_ARB_ROUND_ROBIN_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        vecs[0] = '{1'b0, 1'b0, 15'h1200, 16'h0000, 16'h0001, 16'h0001, 16'h0000};
        vecs[1] = '{1'b1, 1'b1, 15'h1200, 16'h0001, 16'hDEAD, 16'h0001, 16'h0000};
        vecs[2] = '{1'b1, 1'b0, 15'h7FFF, 16'h0000, 16'hBEEF, 16'h0001, 16'hBEEF};
        vecs[3] = '{1'b0, 1'b1, 15'h0003, 16'hFFFF, 16'h1111, 16'h0001, 16'hBEEF};
        vecs[4] = '{1'b0, 1'b0, 15'h0000, 16'h8000, 16'h8000, 16'h8000, 16'hBEEF};
        vecs[5] = '{1'b1, 1'b0, 15'h4AAA, 16'h0000, 16'h5A5A, 16'h8000, 16'h5A5A};
        after_rst = '{1'b0, 1'b0, 15'h0100, 16'h0000, 16'h0CAF, 16'h0CAF, 16'h0000};

        reset_i = 1'b1;
        m0_req = 0; m0_rd_wr = 0; m0_address = '0; m0_data = '0;
        m1_req = 0; m1_rd_wr = 0; m1_address = '0; m1_data = '0;
        bus_data_i = '0;
        tick();
        tick();
        chk("rst_acks", 32'({m1_ack_o, m0_ack_o}), 32'd0);
        chk("rst_m0_data", 32'(m0_data_o), 32'd0);
        chk("rst_m1_data", 32'(m1_data_o), 32'd0);
        chk("rst_addr", 32'(bus_address_o), 32'd0);
        chk("rst_wdata", 32'(bus_data_o), 32'd0);
        chk("rst_strobe", 32'(bus_rd_wr_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        reset_i = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // ReadLatency 1 on the second instance
        m0_req = 1'b1; m0_address = 15'h2000; m0_rd_wr = 1'b0; bus_data_i = 16'h00A5;
        tick();
        chk("rl1_addr", 32'(o1_bus_address), 32'h2000);
        chk("rl1_early_ack", 32'(o1_m0_ack), 32'd0);
        tick();
        chk("rl1_ack", 32'(o1_m0_ack), 32'd1);
        chk("rl1_data", 32'(o1_m0_data), 32'h00A5);
        clear_reqs();
        tick();
        chk("rl1_idle", 32'({o1_busy, o1_m0_ack}), 32'd0);
        tick();

        // Request dropped during WAIT
        m0_req = 1'b1; m0_address = 15'h0042; m0_rd_wr = 1'b0; bus_data_i = 16'h0077;
        tick();
        tick();
        m0_req = 1'b0;
        tick();
        chk("drop_ack", 32'(m0_ack_o), 32'd1);
        chk("drop_data", 32'(m0_data_o), 32'h0077);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("drop_no_retry", 32'({busy_o, m1_ack_o, m0_ack_o}), 32'd0);
        end

        // Reset during WAIT of a master-1 write
        m1_req = 1'b1; m1_address = 15'h0555; m1_data = 16'h1234; m1_rd_wr = 1'b1;
        tick();
        chk("rstw_strobe", 32'(bus_rd_wr_o), 32'd1);
        tick();
        reset_i = 1'b1;
        m1_req = 1'b0;
        tick();
        chk("rstw_acks", 32'({m1_ack_o, m0_ack_o}), 32'd0);
        chk("rstw_data", 32'({m1_data_o, m0_data_o}), 32'd0);
        chk("rstw_bus", 32'({bus_address_o, bus_data_o}), 32'd0);
        chk("rstw_strobe_busy", 32'({bus_rd_wr_o, busy_o}), 32'd0);
        reset_i = 1'b0;
        tick();
        chk("rstw_ack_after", 32'({m1_ack_o, m0_ack_o}), 32'd0);
        run_vec(after_rst);

        // Continuous tie
        do_reset();
        m0_req = 1'b1; m0_address = 15'h0100; m0_rd_wr = 1'b0;
        m1_req = 1'b1; m1_address = 15'h0101; m1_rd_wr = 1'b0;
        bus_data_i = 16'h3C3C;
        for (int t = 0; t < 4; t++) begin
            w = rr & t[0];
            tick();
            chk("tie_addr", 32'(bus_address_o), w ? 32'h0101 : 32'h0100);
            tick();
            tick();
            chk("tie_ack", 32'({m1_ack_o, m0_ack_o}), w ? 32'd2 : 32'd1);
            tick();
            chk("tie_idle_busy", 32'(busy_o), 32'd0);
        end
        clear_reqs();
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
